// File: rtl/decode_queue.sv
// RV32I decode stage with a small FIFO of decoded entries between the IQ and dispatch.
// The head entry is offered to dispatch, and a stall is applied according to its op class.
module decode_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned OP_W  = 6,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             IQ_flag,
    input  logic [31:0]      IQ_inst,
    input  logic [31:0]      IQ_PC,
    output logic             IQ_ready,
    input  logic             RS_full,
    input  logic             LSB_full,
    input  logic             ROB_full,
    output logic             Dec_flag,
    output logic [OP_W-1:0]  Dis_op,
    output logic [IDX_W-1:0] Dis_rd,
    output logic [31:0]      Dis_imm,
    output logic [31:0]      Dis_PC,
    output logic             Dis_illegal,
    output logic             RF_R1,
    output logic [IDX_W-1:0] RF_rs1,
    output logic             RF_R2,
    output logic [IDX_W-1:0] RF_rs2
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [IDX_W-1:0] rd;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic             illegal;
        logic             r1;
        logic [IDX_W-1:0] rs1;
        logic             r2;
        logic [IDX_W-1:0] rs2;
        logic             mem;
    } entry_t;

    entry_t            fifo [DEPTH];
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count;
    entry_t            dec;
    entry_t            head;
    logic              valid;
    logic              pop;
    logic              push;

    // Decoded op numbering: 1..37 in RV32I listing order (LUI first, AND last).
    always_comb begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
        logic        wr;
        logic        rd1;
        logic        rd2;
        logic        is_mem;
        int unsigned code;
        logic [31:0] imm;
        opc    = IQ_inst[6:0];
        f3     = IQ_inst[14:12];
        f7     = IQ_inst[31:25];
        ill    = 1'b0;
        wr     = 1'b0;
        rd1    = 1'b0;
        rd2    = 1'b0;
        is_mem = 1'b0;
        code   = 0;
        imm    = '0;
        dec    = '0;
        case (opc)
            7'b0110111: begin code = 1; wr = 1'b1; imm = {IQ_inst[31:12], 12'b0}; end
            7'b0010111: begin code = 2; wr = 1'b1; imm = {IQ_inst[31:12], 12'b0}; end
            7'b1101111: begin
                code = 3; wr = 1'b1;
                imm = {{11{IQ_inst[31]}}, IQ_inst[31], IQ_inst[19:12], IQ_inst[20], IQ_inst[30:21], 1'b0};
            end
            7'b1100111: begin
                code = 4; wr = 1'b1; rd1 = 1'b1;
                imm = {{20{IQ_inst[31]}}, IQ_inst[31:20]};
            end
            7'b1100011: begin
                rd1 = 1'b1; rd2 = 1'b1;
                imm = {{19{IQ_inst[31]}}, IQ_inst[31], IQ_inst[7], IQ_inst[30:25], IQ_inst[11:8], 1'b0};
                case (f3)
                    3'b000:  code = 5;
                    3'b001:  code = 6;
                    3'b100:  code = 7;
                    3'b101:  code = 8;
                    3'b110:  code = 9;
                    3'b111:  code = 10;
                    default: ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                wr = 1'b1; rd1 = 1'b1; is_mem = 1'b1;
                imm = {{20{IQ_inst[31]}}, IQ_inst[31:20]};
                case (f3)
                    3'b000:  code = 11;
                    3'b001:  code = 12;
                    3'b010:  code = 13;
                    3'b100:  code = 14;
                    3'b101:  code = 15;
                    default: ill = 1'b1;
                endcase
            end
            7'b0100011: begin
                rd1 = 1'b1; rd2 = 1'b1; is_mem = 1'b1;
                imm = {{20{IQ_inst[31]}}, IQ_inst[31:25], IQ_inst[11:7]};
                if (f3 < 3'b011) code = 16 + 32'(f3);
                else             ill = 1'b1;
            end
            7'b0010011: begin
                wr = 1'b1; rd1 = 1'b1;
                imm = {{20{IQ_inst[31]}}, IQ_inst[31:20]};
                case (f3)
                    3'b000: code = 19;
                    3'b010: code = 20;
                    3'b011: code = 21;
                    3'b100: code = 22;
                    3'b110: code = 23;
                    3'b111: code = 24;
                    3'b001: begin code = 25; ill = (f7 != 7'b0000000); end
                    default: begin
                        if (f7 == 7'b0000000)      code = 26;
                        else if (f7 == 7'b0100000) code = 27;
                        else                       ill = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                wr = 1'b1; rd1 = 1'b1; rd2 = 1'b1;
                code = 30 + 32'(f3);
                if (f3 == 3'b000 || f3 == 3'b101) begin
                    if (f7 == 7'b0100000) code = (f3 == 3'b000) ? 29 : 35;
                    else if (f7 == 7'b0000000) code = (f3 == 3'b000) ? 28 : 34;
                    else ill = 1'b1;
                end else begin
                    code = (f3 < 3'b101) ? 29 + 32'(f3) : 30 + 32'(f3);
                    ill  = (f7 != 7'b0000000);
                end
            end
            default: ill = 1'b1;
        endcase
        dec.pc = IQ_PC;
        if (ill) begin
            dec.illegal = 1'b1;
        end else begin
            dec.op  = OP_W'(code);
            dec.rd  = wr ? IQ_inst[11:7] : '0;
            dec.imm = imm;
            dec.r1  = rd1;
            dec.rs1 = rd1 ? IQ_inst[19:15] : '0;
            dec.r2  = rd2;
            dec.rs2 = rd2 ? IQ_inst[24:20] : '0;
            dec.mem = is_mem;
        end
    end

    assign valid = (count != '0);
    assign head  = valid ? fifo[head_ptr] : '0;

    // Illegal entries bypass the RS/LSB stall so the ROB can trap them in order.
    always_comb begin
        pop = valid && rdy_in && !clear_in && !ROB_full;
        if (!head.illegal) begin
            if (head.mem) pop = pop && !LSB_full;
            else          pop = pop && !RS_full;
        end
    end

    assign IQ_ready = rdy_in && ((count < CNT_W'(DEPTH)) || pop);
    assign push     = IQ_flag && IQ_ready && !clear_in;
    assign Dec_flag = pop;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count    <= '0;
            end else begin
                if (pop)  head_ptr <= head_ptr + PTR_W'(1);
                if (push) tail_ptr <= tail_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) fifo[tail_ptr] <= dec;
    end

    assign Dis_op      = head.op;
    assign Dis_rd      = head.rd;
    assign Dis_imm     = head.imm;
    assign Dis_PC      = head.pc;
    assign Dis_illegal = head.illegal;
    assign RF_R1       = head.r1;
    assign RF_rs1      = head.rs1;
    assign RF_R2       = head.r2;
    assign RF_rs2      = head.rs2;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: expected decodes are queued on accept and checked at the head.
module tb_decode_queue;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, rdy, clr, flag, rs, lsb, rob;
    logic [31:0] inst, pc;
    logic        IQ_ready, Dec_flag, Dis_illegal, RF_R1, RF_R2;
    logic [5:0]  Dis_op;
    logic [4:0]  Dis_rd, RF_rs1, RF_rs2;
    logic [31:0] Dis_imm, Dis_PC;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .OP_W(6), .IDX_W(5)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr),
        .IQ_flag(flag), .IQ_inst(inst), .IQ_PC(pc), .IQ_ready(IQ_ready),
        .RS_full(rs), .LSB_full(lsb), .ROB_full(rob),
        .Dec_flag(Dec_flag), .Dis_op(Dis_op), .Dis_rd(Dis_rd), .Dis_imm(Dis_imm),
        .Dis_PC(Dis_PC), .Dis_illegal(Dis_illegal),
        .RF_R1(RF_R1), .RF_rs1(RF_rs1), .RF_R2(RF_R2), .RF_rs2(RF_rs2)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
        logic        r1;
        logic [4:0]  rs1;
        logic        r2;
        logic [4:0]  rs2;
        logic        mem;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hand-decoded reference values for the words used below.
    function automatic exp_t expect_of(input logic [31:0] w, input logic [31:0] p);
        exp_t e;
        e = '{op: 6'd0, rd: 5'd0, imm: 32'd0, pc: p, ill: 1'b0, r1: 1'b0,
              rs1: 5'd0, r2: 1'b0, rs2: 5'd0, mem: 1'b0};
        case (w)
            32'h00500093: begin e.op = 6'd19; e.rd = 5'd1; e.imm = 32'd5; e.r1 = 1'b1; end
            32'hFE208CE3: begin e.op = 6'd5; e.imm = 32'hFFFFFFF8; e.r1 = 1'b1; e.rs1 = 5'd1;
                                e.r2 = 1'b1; e.rs2 = 5'd2; end
            32'h0040A103: begin e.op = 6'd13; e.rd = 5'd2; e.imm = 32'd4; e.r1 = 1'b1;
                                e.rs1 = 5'd1; e.mem = 1'b1; end
            32'h402081B3: begin e.op = 6'd29; e.rd = 5'd3; e.r1 = 1'b1; e.rs1 = 5'd1;
                                e.r2 = 1'b1; e.rs2 = 5'd2; end
            32'h0020A423: begin e.op = 6'd18; e.imm = 32'd8; e.r1 = 1'b1; e.rs1 = 5'd1;
                                e.r2 = 1'b1; e.rs2 = 5'd2; e.mem = 1'b1; end
            32'h00100013: begin e.op = 6'd19; e.imm = 32'd1; e.r1 = 1'b1; end
            32'h00309093: begin e.op = 6'd25; e.rd = 5'd1; e.imm = 32'd3; e.r1 = 1'b1;
                                e.rs1 = 5'd1; end
            32'h123452B7: begin e.op = 6'd1; e.rd = 5'd5; e.imm = 32'h12345000; end
            default:      e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // One cycle: check combinational outputs against the model, then advance the model.
    task automatic tick();
        logic ep;
        logic er;
        logic push;
        exp_t h;
        ep = 1'b0;
        er = 1'b0;
        #1;
        if (!rst) begin
            if (sb.size() > 0) begin
                h  = sb[0];
                ep = rdy && !clr && !rob && (h.ill || (h.mem ? !lsb : !rs));
            end
            er = rdy && ((sb.size() < DEPTH) || ep);
            check("iq_ready", 32'(IQ_ready), 32'(er));
            check("dec_flag", 32'(Dec_flag), 32'(ep));
            if (sb.size() > 0) begin
                check("dis_op", 32'(Dis_op), 32'(h.op));
                check("dis_rd", 32'(Dis_rd), 32'(h.rd));
                check("dis_pc", Dis_PC, h.pc);
                check("dis_illegal", 32'(Dis_illegal), 32'(h.ill));
                check("rf_r1", 32'(RF_R1), 32'(h.r1));
                check("rf_r2", 32'(RF_R2), 32'(h.r2));
                if (!h.ill) begin
                    check("dis_imm", Dis_imm, h.imm);
                    check("rf_rs1", 32'(RF_rs1), 32'(h.rs1));
                    check("rf_rs2", 32'(RF_rs2), 32'(h.rs2));
                end
            end else begin
                check("empty_ctl", 32'({Dis_illegal, RF_R1, RF_R2}), 32'd0);
                check("empty_fld", 32'({Dis_op, Dis_rd, RF_rs1, RF_rs2}), 32'd0);
                check("empty_imm", Dis_imm, 32'd0);
                check("empty_pc", Dis_PC, 32'd0);
            end
        end
        push = flag && er && !clr;
        @(posedge clk);
        if (rst) begin
            sb.delete();
        end else if (rdy) begin
            if (clr) begin
                sb.delete();
            end else begin
                if (ep)   void'(sb.pop_front());
                if (push) sb.push_back(expect_of(inst, pc));
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic f, input logic [31:0] w, input logic [31:0] p);
        flag = f;
        inst = w;
        pc   = p;
        tick();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; flag = 1'b0;
        rs = 1'b0; lsb = 1'b0; rob = 1'b0; inst = '0; pc = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        drive(1'b1, 32'h00500093, 32'h00);
        drive(1'b1, 32'hFE208CE3, 32'h10);
        drive(1'b0, 32'h0, 32'h0);

        // LSB stall holds the load; FIFO fills and refills on the pop cycle.
        lsb = 1'b1;
        drive(1'b1, 32'h0040A103, 32'h20);
        drive(1'b1, 32'h402081B3, 32'h24);
        drive(1'b1, 32'h0020A423, 32'h28);
        drive(1'b1, 32'h0020A423, 32'h28);
        lsb = 1'b0;
        drive(1'b1, 32'h0020A423, 32'h28);
        drive(1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);

        // Illegal entries ignore RS_full but honour ROB_full.
        rs = 1'b1;
        drive(1'b1, 32'h00000000, 32'h40);
        drive(1'b0, 32'h0, 32'h0);
        rs = 1'b0; rob = 1'b1;
        drive(1'b1, 32'h202081B3, 32'h44);
        drive(1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        rob = 1'b0;
        drive(1'b1, 32'hFE20ACE3, 32'h48);
        drive(1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);

        // Flush while full drops the incoming word.
        rs = 1'b1;
        drive(1'b1, 32'h00100013, 32'h50);
        drive(1'b1, 32'h00309093, 32'h54);
        drive(1'b0, 32'h0, 32'h0);
        clr = 1'b1;
        drive(1'b1, 32'h123452B7, 32'h58);
        clr = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        rs = 1'b0;
        drive(1'b1, 32'h123452B7, 32'h5C);
        drive(1'b0, 32'h0, 32'h0);

        // Reset beats rdy_in = 0 while full.
        rs = 1'b1;
        drive(1'b1, 32'h00500093, 32'h60);
        drive(1'b1, 32'h00309093, 32'h64);
        rdy = 1'b0;
        drive(1'b1, 32'h123452B7, 32'h68);
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b0; rdy = 1'b1;
        drive(1'b0, 32'h0, 32'h0);

        // rdy_in = 0 freezes a pending entry.
        rs = 1'b0;
        drive(1'b1, 32'h00500093, 32'h70);
        rdy = 1'b0;
        drive(1'b1, 32'hFE208CE3, 32'h74);
        drive(1'b0, 32'h0, 32'h0);
        rdy = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
